// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Provides IF-stage next-PC prediction and EX-stage mispredict detection with redirect.
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [31:0] ifPC,
    output logic        predTaken,
    output logic [31:0] predTarget,
    input  logic        exValid,
    input  logic        exIsBranch,
    input  logic [31:0] exPC,
    input  logic        exTaken,
    input  logic [31:0] exTarget,
    input  logic        exPredTaken,
    input  logic [31:0] exPredTarget,
    output logic        mispredict,
    output logic [31:0] redirectPC,
    output logic [31:0] branchCount,
    output logic [31:0] missCount
);

    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    logic                  update_en, stray_en;
    logic                  dir_wrong, tgt_wrong;
    logic                  unused_pc_bits;

    // Word-aligned PCs: the low two bits never carry information.
    assign unused_pc_bits = &{1'b0, ifPC[1:0], exPC[1:0]};

    assign if_idx = ifPC[INDEX_BITS+1:2];
    assign if_tag = ifPC[31:INDEX_BITS+2];
    assign ex_idx = exPC[INDEX_BITS+1:2];
    assign ex_tag = exPC[31:INDEX_BITS+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        predTaken  = if_hit && ctr_q[if_idx][1];
        predTarget = predTaken ? target_q[if_idx] : ifPC + 32'd4;
    end

    assign update_en = exValid && exIsBranch;
    assign stray_en  = exValid && !exIsBranch && exPredTaken;
    assign dir_wrong = exTaken != exPredTaken;
    assign tgt_wrong = exTaken && (exTarget != exPredTarget);

    always_comb begin
        mispredict = 1'b0;
        if (resetN && exValid) begin
            if (exIsBranch) begin
                mispredict = dir_wrong || tgt_wrong;
            end else begin
                mispredict = exPredTaken;
            end
        end
        redirectPC = (exIsBranch && exTaken) ? exTarget : exPC + 32'd4;
    end

    always_comb begin
        valid_d        = valid_q;
        tag_d          = tag_q;
        target_d       = target_q;
        ctr_d          = ctr_q;
        branch_count_d = branch_count_q;
        miss_count_d   = miss_count_q;

        if (update_en) begin
            branch_count_d = branch_count_q + 32'd1;
            if (ex_hit) begin
                if (exTaken) begin
                    ctr_d[ex_idx]    = ctr_sat_inc(ctr_q[ex_idx]);
                    target_d[ex_idx] = exTarget;
                end else begin
                    ctr_d[ex_idx] = ctr_sat_dec(ctr_q[ex_idx]);
                end
            end else if (exTaken) begin
                // Allocation evicts whatever occupies this index.
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = exTarget;
                ctr_d[ex_idx]    = 2'b10;
            end
        end

        // A non-branch predicted taken means a stale entry; drop it.
        if (stray_en && ex_hit) begin
            valid_d[ex_idx] = 1'b0;
        end

        if (mispredict) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            valid_q        <= valid_d;
            tag_q          <= tag_d;
            target_q       <= target_d;
            ctr_q          <= ctr_d;
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign branchCount = branch_count_q;
    assign missCount   = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, loop behaviour,
// counter saturation, index collisions, stray predictions and mid-run reset.
module tb_branch_predictor;

    logic        clock;
    logic        resetN;
    logic [31:0] ifPC;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        exValid;
    logic        exIsBranch;
    logic [31:0] exPC;
    logic        exTaken;
    logic [31:0] exTarget;
    logic        exPredTaken;
    logic [31:0] exPredTarget;
    logic        mispredict;
    logic [31:0] redirectPC;
    logic [31:0] branchCount;
    logic [31:0] missCount;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PC_A  = 32'h0040_0020;
    localparam logic [31:0] PC_B  = 32'h0040_0060;
    localparam logic [31:0] TGT_A = 32'h0040_0008;
    localparam logic [31:0] TGT_B = 32'h0040_0200;
    localparam logic [31:0] TGT_C = 32'h0040_0100;

    branch_predictor #(.INDEX_BITS(4)) dut (
        .clock(clock),
        .resetN(resetN),
        .ifPC(ifPC),
        .predTaken(predTaken),
        .predTarget(predTarget),
        .exValid(exValid),
        .exIsBranch(exIsBranch),
        .exPC(exPC),
        .exTaken(exTaken),
        .exTarget(exTarget),
        .exPredTaken(exPredTaken),
        .exPredTarget(exPredTarget),
        .mispredict(mispredict),
        .redirectPC(redirectPC),
        .branchCount(branchCount),
        .missCount(missCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] ptgt);
        exValid      = v;
        exIsBranch   = br;
        exPC         = pc;
        exTaken      = tk;
        exTarget     = tgt;
        exPredTaken  = pt;
        exPredTarget = ptgt;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        pt;
        logic [31:0] ptg;
        logic        tk;
        int          loop_miss;

        // Reset held for two edges with a would-be mispredict on the EX inputs
        resetN = 1'b0;
        ifPC   = 32'h0040_0010;
        drive_ex(1'b1, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, 32'h0);
        #1;
        chk("mp_forced_low_in_reset", {31'b0, mispredict}, 32'd0);
        tick();
        tick();
        resetN = 1'b1;
        idle();
        #1;
        chk("rst_predTaken", {31'b0, predTaken}, 32'd0);
        chk("rst_predTarget", predTarget, 32'h0040_0014);
        chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
        chk("rst_branchCount", branchCount, 32'd0);
        chk("rst_missCount", missCount, 32'd0);

        // Cold taken branch; lookup of the same PC in the same cycle sees the miss
        ifPC = PC_A;
        drive_ex(1'b1, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, PC_A + 32'd4);
        #1;
        chk("cold_mispredict", {31'b0, mispredict}, 32'd1);
        chk("cold_redirect", redirectPC, TGT_A);
        chk("cold_same_cycle_lookup", {31'b0, predTaken}, 32'd0);
        tick();
        idle();
        #1;
        chk("cold_next_predTaken", {31'b0, predTaken}, 32'd1);
        chk("cold_next_predTarget", predTarget, TGT_A);
        chk("cold_branchCount", branchCount, 32'd1);
        chk("cold_missCount", missCount, 32'd1);

        // Fresh table, then a ten-iteration loop with predictions fed back
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        loop_miss = 0;
        for (int i = 0; i < 10; i++) begin
            ifPC = PC_A;
            #1;
            pt  = predTaken;
            ptg = predTarget;
            tk  = (i < 9);
            drive_ex(1'b1, 1'b1, PC_A, tk, tk ? TGT_A : 32'h0, pt, ptg);
            #1;
            if (mispredict) loop_miss++;
            chk($sformatf("loop_mp_%0d", i), {31'b0, mispredict}, (i == 0 || i == 9) ? 32'd1 : 32'd0);
            if (i == 9) chk("loop_exit_redirect", redirectPC, 32'h0040_0024);
            tick();
            idle();
        end
        #1;
        chk("loop_miss_total", loop_miss, 32'd2);
        chk("loop_missCount", missCount, 32'd2);
        chk("loop_branchCount", branchCount, 32'd10);
        chk("loop_still_taken", {31'b0, predTaken}, 32'd1);

        // Five not-taken updates drive the counter to 00
        for (int i = 0; i < 5; i++) begin
            ifPC = PC_A;
            #1;
            pt  = predTaken;
            ptg = predTarget;
            drive_ex(1'b1, 1'b1, PC_A, 1'b0, 32'h0, pt, ptg);
            tick();
            idle();
        end
        #1;
        chk("sat_predTaken", {31'b0, predTaken}, 32'd0);
        chk("sat_predTarget", predTarget, 32'h0040_0024);
        // Entry still valid at 00: one taken step reaches only 01
        drive_ex(1'b1, 1'b1, PC_A, 1'b1, TGT_C, 1'b0, 32'h0040_0024);
        tick();
        idle();
        #1;
        chk("sat_valid_kept", {31'b0, predTaken}, 32'd0);
        drive_ex(1'b1, 1'b1, PC_A, 1'b1, TGT_C, 1'b0, 32'h0040_0024);
        tick();
        idle();
        #1;
        chk("sat_recover_taken", {31'b0, predTaken}, 32'd1);
        chk("sat_recover_target", predTarget, TGT_C);
        chk("sat_branchCount", branchCount, 32'd17);
        chk("sat_missCount", missCount, 32'd5);

        // Two PCs sharing index 8 evict each other
        ifPC = PC_A;
        drive_ex(1'b1, 1'b1, PC_B, 1'b1, TGT_B, 1'b0, PC_B + 32'd4);
        #1;
        chk("coll_same_cycle_old", {31'b0, predTaken}, 32'd1);
        tick();
        idle();
        #1;
        chk("alias_A_evicted", {31'b0, predTaken}, 32'd0);
        chk("alias_A_target", predTarget, 32'h0040_0024);
        ifPC = PC_B;
        #1;
        chk("alias_B_taken", {31'b0, predTaken}, 32'd1);
        chk("alias_B_target", predTarget, TGT_B);
        drive_ex(1'b1, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, PC_A + 32'd4);
        tick();
        idle();
        #1;
        chk("alias_B_evicted", {31'b0, predTaken}, 32'd0);
        chk("alias_branchCount", branchCount, 32'd19);
        chk("alias_missCount", missCount, 32'd7);

        // Stray prediction on a non-branch invalidates the entry
        ifPC = PC_A;
        drive_ex(1'b1, 1'b0, PC_A, 1'b0, 32'h0, 1'b1, TGT_A);
        #1;
        chk("stray_mispredict", {31'b0, mispredict}, 32'd1);
        chk("stray_redirect", redirectPC, 32'h0040_0024);
        tick();
        idle();
        #1;
        chk("stray_invalidated", {31'b0, predTaken}, 32'd0);
        chk("stray_branchCount", branchCount, 32'd19);
        chk("stray_missCount", missCount, 32'd8);

        // Right direction, wrong target
        drive_ex(1'b1, 1'b1, PC_A, 1'b1, TGT_A, 1'b1, 32'h0040_0010);
        #1;
        chk("tgt_mispredict", {31'b0, mispredict}, 32'd1);
        chk("tgt_redirect", redirectPC, TGT_A);
        tick();
        drive_ex(1'b0, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, 32'h0);
        #1;
        chk("invalid_ex_no_mp", {31'b0, mispredict}, 32'd0);
        chk("tgt_alloc_taken", {31'b0, predTaken}, 32'd1);
        chk("tgt_missCount", missCount, 32'd9);

        // Reset coinciding with a taken update
        resetN = 1'b0;
        drive_ex(1'b1, 1'b1, PC_B, 1'b1, TGT_B, 1'b0, 32'h0);
        #1;
        chk("midrst_mp_low", {31'b0, mispredict}, 32'd0);
        tick();
        resetN = 1'b1;
        idle();
        ifPC = PC_A;
        #1;
        chk("midrst_A_cleared", {31'b0, predTaken}, 32'd0);
        chk("midrst_A_target", predTarget, 32'h0040_0024);
        ifPC = PC_B;
        #1;
        chk("midrst_B_not_alloc", {31'b0, predTaken}, 32'd0);
        chk("midrst_branchCount", branchCount, 32'd0);
        chk("midrst_missCount", missCount, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and control-hazard resolver for the five-stage pipeline CPU. IF looks up the fetch PC and receives a predicted next PC. EX reports the resolved outcome of each control-transfer instruction and receives a mispredict/flush request with the corrected PC. The block replaces static predict-not-taken flushing, so backward loop branches in control-hazard programs stop costing two bubbles per iteration.

## Interface
- `INDEX_BITS`, default 4: table index width; the table has 2^INDEX_BITS entries.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `resetN`  in  1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `ifPC`  in  32: PC currently being fetched.
- `predTaken`  out  1: IF should redirect to `predTarget`.
- `predTarget`  out  32: predicted next PC for `ifPC`.
- `exValid`  in  1: EX holds a real, non-bubble, non-stalled instruction this cycle.
- `exIsBranch`  in  1: EX instruction is a branch or jump (`beq`, `bne`, `j`, `jal`, `jr`).
- `exPC`  in  32: PC of the EX instruction.
- `exTaken`  in  1: resolved direction.
- `exTarget`  in  32: resolved target; only meaningful when `exTaken` is 1.
- `exPredTaken`  in  1: `predTaken` value carried down the pipe with this instruction.
- `exPredTarget`  in  32: `predTarget` value carried down the pipe with this instruction.
- `mispredict`  out  1: flush IF/ID and ID/EX and redirect fetch.
- `redirectPC`  out  32: corrected fetch PC.
- `branchCount`  out  32: number of resolved control-transfer instructions.
- `missCount`  out  32: number of mispredicts.

## Operation
- **Entry fields:** `valid`, tag, 32-bit target, and a 2-bit saturating counter `ctr`.
- **Address split:** index = `pc[INDEX_BITS+1:2]`; tag = `pc[31:INDEX_BITS+2]`, so the tag is the full remaining PC and entries cannot alias.
- **Lookup (combinational on `ifPC`, from registered state):**
  - hit = `valid` and tag match.
  - `predTaken` = hit and `ctr[1]`.
  - `predTarget` = the stored target when `predTaken` is 1, else `ifPC`+4, with a 32-bit wraparound add.
- **Mispredict (combinational):** asserted when `resetN` is high and `exValid` is high, and either:
  - `exIsBranch` is 1 and (`exTaken` differs from `exPredTaken`, or `exTaken` is 1 and `exTarget` differs from `exPredTarget`); or
  - `exIsBranch` is 0 and `exPredTaken` is 1.
- **Redirect:** `redirectPC` = `exTarget` when `exIsBranch` and `exTaken` are both 1, else `exPC`+4.
- **Update** (clock edge, only when `exValid` and `exIsBranch` are both 1):
  - Hit at `exPC`:
    - taken: `ctr` saturates upward to 11, and the stored target is overwritten with `exTarget`;
    - not taken: `ctr` saturates downward to 00.
  - Miss and taken: allocate the entry, overwriting any occupant. Set `valid`=1, tag from `exPC`, target=`exTarget`, `ctr`=10.
  - Miss and not taken: no change.
- **Invalidate:** when `exValid` is 1, `exIsBranch` is 0 and `exPredTaken` is 1, clear `valid` at the index of `exPC` if the tag matches.
- **Statistics:** `branchCount` increments on each update event. `missCount` increments whenever `mispredict` is 1 at the edge. Both wrap modulo 2^32.

## Timing
- **Reset** (`resetN` low at an edge):
  - every `valid`=0, every `ctr`=01, every target=0;
  - `branchCount`=0 and `missCount`=0;
  - `mispredict` is forced to 0 while `resetN` is low.
- **Outputs after reset:** `predTaken`=0 and `predTarget`=`ifPC`+4.
- **Latency:**
  - lookup and mispredict are zero-cycle combinational;
  - a table update becomes visible to lookups the cycle after the edge.
- **Same-index collision:** when an IF lookup and an EX update hit the same index in one cycle, the lookup returns pre-update contents.
- **Reset wins:** a reset asserted mid-operation takes priority over a simultaneous update or count increment in that cycle.
- **Stalls:** the pipeline deasserts `exValid` during EX stalls and bubbles. A held instruction is therefore counted and updated exactly once.
- **Flush handling:** the pipeline must drop the instruction in IF the same cycle `mispredict` is 1. Wrong-path instructions never reach EX with `exValid`=1.

## Test plan
- **Reset state:** hold `resetN`=0 for 2 cycles, then release. Require `predTaken`=0, `predTarget`=`ifPC`+4 for `ifPC`=0x00400010, `mispredict`=0, and both counts 0.
- **Cold taken branch:** `exPC`=0x00400020, taken, `exTarget`=0x00400008, `exPredTaken`=0.
  - Require `mispredict`=1 and `redirectPC`=0x00400008.
  - Next cycle, lookup of 0x00400020 gives `predTaken`=1 and `predTarget`=0x00400008.
  - `branchCount`=1 and `missCount`=1.
- **Loop of 10 iterations:** 9 taken then 1 not-taken at 0x00400020, with predictions fed back.
  - Require exactly 2 mispredicts (first and last), and `redirectPC`=0x00400024 on the exit.
  - Counter ends at 10, so the prediction is still taken.
- **Saturation:** 5 consecutive not-taken updates on an allocated entry. The counter saturates at 00, `predTaken`=0, and `valid` stays 1.
- **Collision and aliasing:**
  - Taken branches at 0x00400020 and 0x00400060 (same index when `INDEX_BITS`=4) evict each other: the lookup of 0x00400020 misses after the second allocation.
  - A same-cycle lookup of 0x00400020 during its own update sees the old state.
- **Stray prediction and reset mid-run:**
  - `exValid`=1, `exIsBranch`=0, `exPredTaken`=1 at a hit PC: require `mispredict`=1, `redirectPC`=`exPC`+4, and the entry invalidated.
  - Assert `resetN`=0 together with a taken update: require the table to be cleared and the counts to be 0.
